// File: rtl/fifo_rd_stream_if.sv
// Bundle of the FIFO read port and the downstream valid/ready stream for fifo_rd_stream.
// The master modport is the adapter's view; the slave modport is the environment's view.
interface fifo_rd_stream_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;
    logic [CNT_W-1:0]  beat_cnt;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_valid,
        output beat_cnt
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid,
        input  beat_cnt
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Drains a one-cycle-latency FIFO onto a valid/ready stream through a 2-entry skid buffer,
// issuing pops only when a buffer slot is guaranteed for the returning word.
module fifo_rd_stream #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              rst_n,
    fifo_rd_stream_if.master bus
);

    logic              inflight;
    logic [DATA_W-1:0] m_data_q;
    logic              m_valid_q;
    logic [DATA_W-1:0] skid_data;
    logic              skid_valid;
    logic [CNT_W-1:0]  beat_cnt_q;

    logic [1:0]        occ;
    logic              pop;
    logic [2:0]        fill_next;
    logic              rd_en;
    logic              load_out_from_skid;
    logic              load_out_from_fifo;
    logic              load_skid;

    function automatic logic [CNT_W-1:0] wrap_inc(input logic [CNT_W-1:0] cnt);
        return cnt + CNT_W'(1);
    endfunction

    assign occ       = {1'b0, m_valid_q} + {1'b0, skid_valid};
    assign pop       = m_valid_q & bus.m_ready;
    assign fill_next = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    // A pop is only issued when the word returning next cycle is sure to find a free slot.
    assign rd_en = rst_n & ~bus.fifo_empty & (fill_next < 3'd2);

    assign load_out_from_skid = pop & skid_valid;
    assign load_out_from_fifo = inflight & ~skid_valid & (pop | ~m_valid_q);
    assign load_skid          = inflight & ~load_out_from_fifo;

    // Stage: pop issued -> word on fifo_dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= rd_en;
        end
    end

    // Stage: fifo_dout -> output / skid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
        end else if (load_out_from_skid) begin
            m_data_q  <= skid_data;
            m_valid_q <= 1'b1;
        end else if (load_out_from_fifo) begin
            m_data_q  <= bus.fifo_dout;
            m_valid_q <= 1'b1;
        end else if (pop) begin
            m_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (load_skid) begin
            skid_data  <= bus.fifo_dout;
            skid_valid <= 1'b1;
        end else if (load_out_from_skid) begin
            skid_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_q <= '0;
        end else if (pop) begin
            beat_cnt_q <= wrap_inc(beat_cnt_q);
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_data     = m_data_q;
    assign bus.m_valid    = m_valid_q;
    assign bus.beat_cnt   = beat_cnt_q;

    a_no_overfill : assert property (@(posedge clk) disable iff (!rst_n)
        ({1'b0, occ} + {2'b0, inflight}) <= 3'd2);

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(rd_en && bus.fifo_empty));

    a_stall_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid_q && !bus.m_ready) |=> (m_valid_q && $stable(m_data_q)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based FIFO model feeds both a 16-bit and a
// 4-bit-counter instance; a negedge monitor checks words, credit, hold and beat counts.
module tb_fifo_rd_stream;
    localparam int DATA_W  = 8;
    localparam int CNT_W   = 16;
    localparam int CNT_W_S = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W))   bus   ();
    fifo_rd_stream_if #(.DATA_W(DATA_W), .CNT_W(CNT_W_S)) bus_s ();

    fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fifo_rd_stream #(.DATA_W(DATA_W), .CNT_W(CNT_W_S)) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s)
    );

    logic              wr_en     = 1'b0;
    logic [DATA_W-1:0] wr_data   = '0;
    logic              ready_drv = 1'b0;
    logic              empty_ovr = 1'b1;

    logic [DATA_W-1:0] fm_q[$];
    logic [DATA_W-1:0] exp_q[$];
    logic              fm_empty    = 1'b1;
    logic [DATA_W-1:0] fm_dout     = '0;
    int                pops_issued = 0;

    int n_vec         = 0;
    int n_fail        = 0;
    int timeouts      = 0;
    int timeouts_seen = 0;

    assign bus.fifo_empty   = fm_empty & ~empty_ovr;
    assign bus.fifo_dout    = fm_dout;
    assign bus.m_ready      = ready_drv;
    assign bus_s.fifo_empty = fm_empty & ~empty_ovr;
    assign bus_s.fifo_dout  = fm_dout;
    assign bus_s.m_ready    = ready_drv;

    // Standard-mode FIFO: registered empty, dout valid the cycle after rd_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fm_q.delete();
            exp_q.delete();
            fm_empty    <= 1'b1;
            fm_dout     <= '0;
            pops_issued <= 0;
        end else begin
            if (bus.fifo_rd_en) begin
                pops_issued <= pops_issued + 1;
                if (fm_q.size() != 0) fm_dout <= fm_q.pop_front();
            end
            if (wr_en) begin
                fm_q.push_back(wr_data);
                exp_q.push_back(wr_data);
            end
            fm_empty <= (fm_q.size() == 0);
        end
    end

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_vec++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    int                beats_done = 0;
    logic              prev_stall = 1'b0;
    logic [DATA_W-1:0] prev_data  = '0;
    logic              prev_empty = 1'b1;
    int                lat_cd     = 0;

    always @(negedge clk) begin
        int                outstanding;
        bit                hs;
        bit                exp_rd;
        logic [DATA_W-1:0] exp_w;
        if (timeouts != timeouts_seen) begin
            check(1'b0, "drain_timeout", timeouts, timeouts_seen);
            timeouts_seen <= timeouts;
        end
        if (!rst_n) begin
            check(bus.fifo_rd_en == 1'b0, "reset_rd_en", bus.fifo_rd_en, 0);
            check(bus.m_valid == 1'b0, "reset_m_valid", bus.m_valid, 0);
            check(bus.m_data == '0, "reset_m_data", bus.m_data, 0);
            check(bus.beat_cnt == '0, "reset_beat_cnt", bus.beat_cnt, 0);
            check(bus_s.beat_cnt == '0, "reset_beat_cnt_s", bus_s.beat_cnt, 0);
            beats_done <= 0;
            prev_stall <= 1'b0;
            prev_empty <= 1'b1;
            lat_cd     <= 0;
        end else begin
            outstanding = pops_issued - beats_done;
            hs          = bus.m_valid & bus.m_ready;
            exp_rd      = !bus.fifo_empty && ((outstanding - int'(hs)) < 2);
            check(bus.fifo_rd_en == exp_rd, "rd_en", bus.fifo_rd_en, exp_rd);
            check(bus_s.fifo_rd_en == exp_rd, "rd_en_s", bus_s.fifo_rd_en, exp_rd);
            check(bus.beat_cnt == CNT_W'(beats_done), "beat_cnt", bus.beat_cnt, CNT_W'(beats_done));
            check(bus_s.beat_cnt == CNT_W_S'(beats_done), "beat_cnt_wrap", bus_s.beat_cnt,
                  CNT_W_S'(beats_done));
            if (prev_stall)
                check(bus.m_valid && (bus.m_data == prev_data), "stall_hold", bus.m_data, prev_data);
            if (lat_cd == 1) check(bus.m_valid == 1'b1, "first_word_latency", bus.m_valid, 1);
            if (lat_cd > 0) lat_cd <= lat_cd - 1;
            else if (prev_empty && !bus.fifo_empty && outstanding == 0) lat_cd <= 2;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_beat", bus.m_data, 0);
                end else begin
                    exp_w = exp_q.pop_front();
                    check(bus.m_data == exp_w, "data", bus.m_data, exp_w);
                    check(bus_s.m_data == exp_w, "data_s", bus_s.m_data, exp_w);
                end
                beats_done <= beats_done + 1;
            end
            prev_stall <= bus.m_valid & ~bus.m_ready;
            prev_data  <= bus.m_data;
            prev_empty <= bus.fifo_empty;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: hold ready, 1: toggle every cycle, 2: random (~70% high)
    task automatic set_ready(input int mode);
        case (mode)
            1:       ready_drv = ~ready_drv;
            2:       ready_drv = ($urandom_range(0, 99) < 70);
            default: ready_drv = ready_drv;
        endcase
    endtask

    task automatic write_seq(input int n, input bit rnd_data, input int mode);
        for (int i = 0; i < n; i++) begin
            wr_en   = 1'b1;
            wr_data = rnd_data ? DATA_W'($urandom) : DATA_W'(i);
            set_ready(mode);
            tick();
        end
        wr_en = 1'b0;
    endtask

    task automatic drain(input int mode);
        int k = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && k < 1000) begin
            set_ready(mode);
            tick();
            k++;
        end
        if (k >= 1000) timeouts++;
        repeat (2) tick();
    endtask

    task automatic random_phase(input int n);
        for (int i = 0; i < n; i++) begin
            wr_en   = ($urandom_range(0, 99) < 55);
            wr_data = DATA_W'($urandom);
            set_ready(2);
            tick();
        end
        wr_en     = 1'b0;
        ready_drv = 1'b1;
        drain(0);
    endtask

    initial begin
        #100;
        tick();
        empty_ovr = 1'b0;
        rst_n     = 1'b1;

        ready_drv = 1'b1;
        write_seq(11, 1'b0, 0);
        drain(0);

        ready_drv = 1'b0;
        write_seq(11, 1'b0, 0);
        repeat (10) tick();
        ready_drv = 1'b1;
        drain(0);

        ready_drv = 1'b1;
        write_seq(11, 1'b0, 1);
        drain(1);

        random_phase(400);

        ready_drv = 1'b0;
        write_seq(6, 1'b1, 0);
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        tick();
        wr_en     = 1'b0;
        ready_drv = 1'b1;
        drain(0);

        random_phase(300);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
